uart_rx_instruction: RTL and testbench

Serial instruction receiver for the interactive RISC-V bench. It deserialises 8N1 UART bytes from the host on `rx` and assembles each group of four bytes into one 32-bit instruction word. It presents the word on `instruction` with a one-cycle `instruction_rcv` strobe. It sits between the host serial line and the top-level sequencer, which gates the CPU clock and injects the word into the instruction path.

---
 rtl/uart_rx_pkg.sv | 13 +
 rtl/uart_rx_byte.sv | 117 +++++++++++
 rtl/uart_rx_instruction.sv | 103 ++++++++++
 tb/tb_uart_rx_instruction.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART instruction receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser plus start/data/stop FSM.
// byte_valid / frame_err are one-cycle pulses registered at the stop-bit sample.
import uart_rx_pkg::*;

module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk12,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
`ifdef RX_TIMEOUT_EN
  ,
  output logic       rx_idle,
  output logic       start_det
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, line_q, line_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             fall;

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= 1'b1;
      line_q      <= 1'b1;
      line_prev_q <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= rx;
      line_q      <= sync1_q;
      line_prev_q <= line_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // Edge detect keeps a line held low after a framing error from re-triggering.
  assign fall = line_prev_q & ~line_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = CNT_W'(1);
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {line_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          valid_d = line_q;
          err_d   = ~line_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

`ifdef RX_TIMEOUT_EN
  assign rx_idle   = (state_q == IDLE);
  assign start_det = (state_q == IDLE) && fall;
`endif

endmodule

// File: rtl/uart_rx_instruction.sv
// Assembles four UART bytes (first byte -> [31:24]) into an instruction word with a 1-cycle strobe.
// Optional inter-byte timeout drops partial words when RX_TIMEOUT_EN is defined.
import uart_rx_pkg::*;

module uart_rx_instruction #(
  parameter int unsigned CLK_FREQ     = 12_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic [31:0] instruction,
  output logic        instruction_rcv
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);

  if (CPB < 4 || TIMEOUT_BITS == 0) begin : g_bad_cfg
    $error("uart_rx_instruction: CLK_FREQ/BAUD must be >= 4 and TIMEOUT_BITS nonzero");
  end

  logic [7:0]  byte_data;
  logic        byte_valid, frame_err;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] instr_q, instr_d;
  logic        rcv_q, rcv_d;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * CPB;
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);
  logic             rx_idle, start_det;
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_byte (
    .clk12      (clk12),
    .rstn       (rstn),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
`ifdef RX_TIMEOUT_EN
    ,
    .rx_idle    (rx_idle),
    .start_det  (start_det)
`endif
  );

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      instr_q <= '0;
      rcv_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      gap_q   <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      instr_q <= instr_d;
      rcv_q   <= rcv_d;
`ifdef RX_TIMEOUT_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    instr_d = instr_q;
    rcv_d   = 1'b0;
    if (frame_err) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (byte_valid) begin
      shreg_d = {shreg_q[23:0], byte_data};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == 2'(WORD_BYTES - 1)) begin
        instr_d = {shreg_q[23:0], byte_data};
        rcv_d   = 1'b1;
      end
    end
`ifdef RX_TIMEOUT_EN
    gap_d = '0;
    if (!start_det && cnt_q != '0 && rx_idle) begin
      if (gap_q >= GAP_W'(GAP_LIMIT)) begin
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
`endif
  end

  assign instruction     = instr_q;
  assign instruction_rcv = rcv_q;

endmodule

// File: tb/tb_uart_rx_instruction.sv
// Directed bench for uart_rx_instruction: word table plus framing, glitch, reset and timeout sequences.
module tb_uart_rx_instruction;

  localparam int CPB     = 104;
  localparam int LATENCY = 991;

  logic        clk12 = 1'b0;
  logic        rstn  = 1'b0;
  logic        rx    = 1'b1;
  logic [31:0] instruction;
  logic        instruction_rcv;

  int errors = 0;
  int checks = 0;

  uart_rx_instruction dut (
    .clk12           (clk12),
    .rstn            (rstn),
    .rx              (rx),
    .instruction     (instruction),
    .instruction_rcv (instruction_rcv)
  );

  always #5 clk12 = ~clk12;

  int          cyc = 0;
  int          strobes = 0;
  int          strobe_cyc = 0;
  int          last_start = 0;
  int          wide_strobes = 0;
  int          bad_changes = 0;
  logic        prev_rcv = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [31:0] last_word = '0;

  always @(posedge clk12) cyc <= cyc + 1;

  always @(negedge clk12) begin
    if (rstn) begin
      if (instruction_rcv) begin
        strobes++;
        strobe_cyc = cyc;
        last_word  = instruction;
        if (prev_rcv) wide_strobes++;
      end else if (instruction !== prev_instr) begin
        bad_changes++;
      end
    end
    prev_rcv   = instruction_rcv;
    prev_instr = instruction;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end #1 after a rising edge so bytes can abut.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk12);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    last_start = cyc;
    repeat (CPB) @(posedge clk12);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk12);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk12);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], 1'b1); idle(gap);
    send_byte(w[23:16], 1'b1); idle(gap);
    send_byte(w[15:8],  1'b1); idle(gap);
    send_byte(w[7:0],   1'b1);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];
  int   s0;

  initial begin
    vecs[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 0,   32'h13000000};
    vecs[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 5,   32'hAABBCCDD};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 300, 32'hFFFFFFFF};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 0,   32'h00000000};
    vecs[4] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 1,   32'h5AA53CC3};

    repeat (4) @(posedge clk12);
    #1;
    check("reset_instruction", instruction, 32'h0);
    check("reset_rcv", {31'b0, instruction_rcv}, 32'h0);
    rstn = 1'b1;
    idle(2000);
    check("idle_instruction", instruction, 32'h0);
    check("idle_strobes", strobes, 0);

    for (int v = 0; v < 5; v++) begin
      s0 = strobes;
      send_byte(vecs[v].b0, 1'b1); idle(vecs[v].gap);
      send_byte(vecs[v].b1, 1'b1); idle(vecs[v].gap);
      send_byte(vecs[v].b2, 1'b1); idle(vecs[v].gap);
      send_byte(vecs[v].b3, 1'b1);
      idle(20);
      check($sformatf("vec%0d_strobes", v), strobes - s0, 1);
      check($sformatf("vec%0d_strobe_word", v), last_word, vecs[v].exp);
      check($sformatf("vec%0d_instruction", v), instruction, vecs[v].exp);
      check($sformatf("vec%0d_latency", v), strobe_cyc - last_start, LATENCY);
    end

    // Eight bytes back-to-back: two words, first held while the second arrives.
    s0 = strobes;
    send_word(32'h93005000, 0);
    check("b2b_first_word", instruction, 32'h93005000);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    check("b2b_hold", instruction, 32'h93005000);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(20);
    check("b2b_strobes", strobes - s0, 2);
    check("b2b_second_word", instruction, 32'h13051000);

    // A good byte followed by a framing error must leave the counter at zero.
    s0 = strobes;
    send_byte(8'h77, 1'b1);
    send_byte(8'h13, 1'b0);
    idle(2 * CPB);
    check("frame_err_no_strobe", strobes - s0, 0);
    send_word(32'hAABBCCDD, 0);
    idle(20);
    check("frame_err_strobes", strobes - s0, 1);
    check("frame_err_word", instruction, 32'hAABBCCDD);

    // Short low glitch shorter than half a bit.
    s0 = strobes;
    rx = 1'b0;
    repeat (20) @(posedge clk12);
    #1;
    idle(200);
    check("glitch_no_strobe", strobes - s0, 0);
    send_word(32'hDEADBEEF, 3);
    idle(20);
    check("glitch_strobes", strobes - s0, 1);
    check("glitch_word", instruction, 32'hDEADBEEF);

    // Reset in the middle of a word discards the partial bytes.
    send_byte(8'hF0, 1'b1);
    send_byte(8'h0F, 1'b1);
    rstn = 1'b0;
    repeat (5) @(posedge clk12);
    #1;
    check("midreset_instruction", instruction, 32'h0);
    check("midreset_rcv", {31'b0, instruction_rcv}, 32'h0);
    rstn = 1'b1;
    idle(10);
    s0 = strobes;
    send_word(32'h01020304, 0);
    idle(20);
    check("midreset_strobes", strobes - s0, 1);
    check("midreset_word", instruction, 32'h01020304);

`ifdef RX_TIMEOUT_EN
    send_byte(8'hF0, 1'b1);
    send_byte(8'h0F, 1'b1);
    idle(70 * CPB);
    s0 = strobes;
    send_word(32'h01020304, 0);
    idle(20);
    check("timeout_strobes", strobes - s0, 1);
    check("timeout_word", instruction, 32'h01020304);
`endif

    check("strobe_width", wide_strobes, 0);
    check("instruction_stable", bad_changes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
